if_fetch: RTL and testbench

- Instruction-fetch stage of the P5 pipeline; producer side of the F→D pipeline register.
- Owns the PC and runs a req/ready handshake with instruction memory.
- Buffers one fetched instruction and presents INS_F/PC_F/valid_F to the F/D register, which captures when en=1.
- Applies D-stage branch/jump redirects with MIPS delay-slot semantics.

---
 rtl/if_fetch_pkg.sv | 13 +
 rtl/if_fetch_if.sv | 23 ++
 rtl/if_fetch_pc_next.sv | 37 +++
 rtl/if_fetch.sv | 119 +++++++++++
 tb/tb_if_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: address defaults, fetch FSM states, NOP.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] TEXT_LIMIT_DEF = 32'h0000_7000;
    localparam logic [31:0] NOP            = 32'h0000_0000;

    typedef enum logic {
        StRun  = 1'b0,
        StWait = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and imem (slave).
interface if_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_pc_next.sv
// Combinational fetch-address and next-PC select, including delay-slot redirect bookkeeping.
module if_pc_next (
    input  logic [31:0] i_pc_q,
    input  logic        i_valid_f,
    input  logic        i_redir,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_redir_pend,
    input  logic [31:0] i_redir_tgt,
    input  logic        i_fetch_done,
    output logic [31:0] o_addr,
    output logic [31:0] o_pc_nxt,
    output logic        o_pend_nxt,
    output logic [31:0] o_tgt_nxt
);

    logic        w_pend_eff;
    logic [31:0] w_tgt_eff;
    logic [31:0] w_addr;

    always_comb begin
        // Slot already buffered and leaving this cycle: fetch the target right away.
        w_addr     = (i_redir && i_valid_f) ? i_redirect_pc : i_pc_q;
        // Slot still to arrive: the next completed fetch is the slot, then jump.
        w_pend_eff = i_redir_pend || (i_redir && !i_valid_f);
        w_tgt_eff  = i_redir_pend ? i_redir_tgt : i_redirect_pc;

        o_addr     = w_addr;
        o_pend_nxt = w_pend_eff && !i_fetch_done;
        o_tgt_nxt  = (i_redir && !i_valid_f) ? i_redirect_pc : i_redir_tgt;
        // Without completion, latching w_addr keeps a redirected WAIT address held.
        o_pc_nxt   = w_addr;
        if (i_fetch_done) begin
            o_pc_nxt = w_pend_eff ? w_tgt_eff : w_addr + 32'd4;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// P5 instruction-fetch stage: PC, imem handshake, one-entry F buffer, delay-slot redirects.
// Optional fetch-address exception checking is enabled with the IF_ADDR_CHECK_EN macro.
module if_fetch
    import if_fetch_pkg::*;
#(
`ifdef IF_ADDR_CHECK_EN
    parameter logic [31:0] TEXT_LIMIT = TEXT_LIMIT_DEF,
`endif
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    if_fetch_if.master  imem,
    output logic [31:0] INS_F,
    output logic [31:0] PC_F,
`ifdef IF_ADDR_CHECK_EN
    output logic        exc_adel_F,
`endif
    output logic        valid_F
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, r_ins, r_pc_f, r_redir_tgt;
    logic         r_valid, r_redir_pend;

    logic         w_redir, w_want, w_bad, w_fetch_done, w_pend_nxt;
    logic [31:0]  w_addr, w_pc_nxt, w_tgt_nxt;

    assign w_redir = redirect_valid && en;
    // WAIT implies an empty buffer, so this also keeps the request up while waiting.
    assign w_want  = (r_state == StWait) || !r_valid || en;

`ifdef IF_ADDR_CHECK_EN
    assign w_bad = (r_state == StRun) &&
                   ((w_addr[1:0] != 2'b00) || (w_addr < RESET_PC) || (w_addr >= TEXT_LIMIT));
`else
    assign w_bad = 1'b0;
`endif

    assign w_fetch_done   = w_want && (w_bad || imem.imem_ready);
    assign imem.imem_req  = reset && w_want && !w_bad;
    assign imem.imem_addr = w_addr;

    if_pc_next u_pc_next (
        .i_pc_q        (r_pc),
        .i_valid_f     (r_valid),
        .i_redir       (w_redir),
        .i_redirect_pc (redirect_pc),
        .i_redir_pend  (r_redir_pend),
        .i_redir_tgt   (r_redir_tgt),
        .i_fetch_done  (w_fetch_done),
        .o_addr        (w_addr),
        .o_pc_nxt      (w_pc_nxt),
        .o_pend_nxt    (w_pend_nxt),
        .o_tgt_nxt     (w_tgt_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun:   if (w_want && !w_bad && !imem.imem_ready) w_state_nxt = StWait;
            StWait:  if (imem.imem_ready) w_state_nxt = StRun;
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StRun;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= 32'd0;
            r_valid      <= 1'b0;
            r_ins        <= NOP;
            r_pc_f       <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_redir_pend <= w_pend_nxt;
            r_redir_tgt  <= w_tgt_nxt;
            if (w_fetch_done) begin
                r_valid <= 1'b1;
                r_ins   <= w_bad ? NOP : imem.imem_rdata;
                r_pc_f  <= w_addr;
            end else if (r_valid && en) begin
                r_valid <= 1'b0;
                r_ins   <= NOP;
            end
        end
    end

`ifdef IF_ADDR_CHECK_EN
    logic r_exc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exc <= 1'b0;
        end else if (w_fetch_done) begin
            r_exc <= w_bad;
        end else if (r_valid && en) begin
            r_exc <= 1'b0;
        end
    end

    assign exc_adel_F = r_exc;
`endif

    assign INS_F   = r_ins;
    assign PC_F    = r_pc_f;
    assign valid_F = r_valid;

    // A second branch before the first one's delay slot has been fetched is illegal.
    a_redir_while_pend: assert property (@(posedge clk) disable iff (!reset)
        !(w_redir && r_redir_pend));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed delay-slot/stall/wait scenarios, then random en/ready/redirects
// checked every cycle against a delivered-instruction-stream model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    logic        r_ready;
    logic [31:0] INS_F, PC_F;
    logic        valid_F;
`ifdef IF_ADDR_CHECK_EN
    logic        exc_adel_F;
`endif

    int checks   = 0;
    int failures = 0;

    // Model of the instruction stream seen by D.
    logic [31:0] m_expect, m_tgt;
    logic        m_after;
    int          m_deliv;
    logic        p_load, p_hold;
    logic [31:0] p_load_addr, p_hold_addr;

    if_fetch_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
`ifdef IF_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
`else
        return (a == 32'h0) && 1'b0;
`endif
    endfunction

    assign bus.imem_ready = r_ready;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    if_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .redirect_valid (rv),
        .redirect_pc    (rpc),
        .imem           (bus),
        .INS_F          (INS_F),
        .PC_F           (PC_F),
`ifdef IF_ADDR_CHECK_EN
        .exc_adel_F     (exc_adel_F),
`endif
        .valid_F        (valid_F)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Per-cycle comparison against the stream model and handshake rules.
    always @(negedge clk) begin
        logic [31:0] exp_ins;
        if (!reset) begin
            m_expect = 32'h0000_3000;
            m_after  = 1'b0;
            m_deliv  = 0;
            p_load   = 1'b0;
            p_hold   = 1'b0;
        end else begin
            if (p_load) begin
                chk("load_valid", {31'd0, valid_F}, 32'd1);
                chk("load_pc", PC_F, p_load_addr);
            end
            if (p_hold) begin
                chk("hold_req", {31'd0, bus.imem_req}, 32'd1);
                chk("hold_addr", bus.imem_addr, p_hold_addr);
            end
            chk("req_rule", {31'd0, bus.imem_req},
                {31'd0, (!valid_F || en) && !bad_addr(bus.imem_addr)});
            exp_ins = valid_F ? mem_word(PC_F) : 32'd0;
`ifdef IF_ADDR_CHECK_EN
            if (exc_adel_F) exp_ins = 32'd0;
`endif
            chk("ins_f", INS_F, exp_ins);
            if (valid_F && en) begin
                chk("d_seq", PC_F, m_expect);
                m_deliv++;
                if (rv) begin
                    m_expect = rpc;
                end else begin
                    m_expect = m_after ? m_tgt : m_expect + 32'd4;
                    m_after  = 1'b0;
                end
            end else if (rv && en) begin
                m_after = 1'b1;
                m_tgt   = rpc;
            end
            p_load      = bus.imem_req && r_ready;
            p_load_addr = bus.imem_addr;
            p_hold      = bus.imem_req && !r_ready;
            p_hold_addr = bus.imem_addr;
        end
    end

    initial begin
        int start_deliv;
        reset = 1'b0; en = 1'b1; r_ready = 1'b1; rv = 1'b0; rpc = 32'd0;
        repeat (2) smp();
        chk("rst_valid", {31'd0, valid_F}, 32'd0);
        chk("rst_ins", INS_F, 32'd0);
        chk("rst_pc_f", PC_F, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);

        cyc(); reset = 1'b1; smp();
        chk("rel_addr", bus.imem_addr, 32'h3000);
        chk("rel_valid", {31'd0, valid_F}, 32'd0);
        cyc(); smp();
        chk("first_pc", PC_F, 32'h3000);
        chk("first_valid", {31'd0, valid_F}, 32'd1);
        // Branch 0x3000 now in D, slot 0x3004 in F.
        cyc(); rv = 1'b1; rpc = 32'h3100; smp();
        chk("slot_pc", PC_F, 32'h3004);
        chk("redir_addr", bus.imem_addr, 32'h3100);
        cyc(); rv = 1'b0; smp();
        chk("tgt_pc", PC_F, 32'h3100);

        cyc(); en = 1'b0; smp();
        chk("stall_pc", PC_F, 32'h3104);
        for (int i = 0; i < 2; i++) begin
            cyc(); smp();
            chk("stall_hold", PC_F, 32'h3104);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        cyc(); en = 1'b1; smp();
        chk("resume_addr", bus.imem_addr, 32'h3108);
        cyc(); smp();
        chk("resume_pc", PC_F, 32'h3108);

        cyc(); r_ready = 1'b0; smp();
        chk("pre_wait_pc", PC_F, 32'h310C);
        cyc(); smp();
        chk("wait_valid", {31'd0, valid_F}, 32'd0);
        chk("wait_addr", bus.imem_addr, 32'h3110);
        cyc(); r_ready = 1'b1; smp();
        chk("wait_addr2", bus.imem_addr, 32'h3110);
        cyc(); r_ready = 1'b0; smp();
        chk("wait_load", PC_F, 32'h3110);

        // Branch 0x3110 enters D while its slot 0x3114 is still in flight.
        cyc(); rv = 1'b1; rpc = 32'h3200; smp();
        chk("inflight_addr", bus.imem_addr, 32'h3114);
        cyc(); rv = 1'b0; r_ready = 1'b1; smp();
        chk("inflight_hold", bus.imem_addr, 32'h3114);
        cyc(); r_ready = 1'b0; smp();
        chk("slot2_pc", PC_F, 32'h3114);
        chk("after_slot_addr", bus.imem_addr, 32'h3200);
        cyc(); smp();
        chk("wait2_addr", bus.imem_addr, 32'h3200);
        #2 reset = 1'b0;
        #1;
        chk("async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_pc_f", PC_F, 32'd0);
        chk("async_valid", {31'd0, valid_F}, 32'd0);
        smp();
        cyc(); reset = 1'b1; r_ready = 1'b1; smp();
        chk("refetch_addr", bus.imem_addr, 32'h3000);
        cyc(); smp();
        chk("refetch_pc", PC_F, 32'h3000);

`ifdef IF_ADDR_CHECK_EN
        cyc(); rv = 1'b1; rpc = 32'h3102; smp();
        chk("adel_noreq", {31'd0, bus.imem_req}, 32'd0);
        cyc(); rv = 1'b0; smp();
        chk("adel_pc", PC_F, 32'h3102);
        chk("adel_ins", INS_F, 32'd0);
        chk("adel_exc", {31'd0, exc_adel_F}, 32'd1);
        #2 reset = 1'b0;
        smp();
        cyc(); reset = 1'b1;
`endif

        start_deliv = m_deliv;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            en      = ($urandom_range(0, 3) != 0);
            r_ready = ($urandom_range(0, 2) != 0);
            rpc     = 32'h3000 + ($urandom_range(0, 4095) << 2);
            if (en) rv = (m_deliv > 0) && !m_after && ($urandom_range(0, 7) == 0);
            else    rv = ($urandom_range(0, 3) == 0);
        end
        smp();
        chk("progress", {31'd0, (m_deliv - start_deliv) > 500}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
